// File: rtl/clock_pkg.sv
// Shared definitions for the clock tick generator: speed-mode encodings,
// default speed-up factors and the divisor helper used for both the
// divisor table and the elaboration-time legality checks.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_X1 = 2'd0,
    MODE_S1 = 2'd1,
    MODE_S2 = 2'd2,
    MODE_S3 = 2'd3
  } mode_e;

  localparam int CLK_HZ_DEF  = 50_000_000;
  localparam int TICK_HZ_DEF = 1;
  localparam int SPD1_DEF    = 100;
  localparam int SPD2_DEF    = 500;
  localparam int SPD3_DEF    = 50000;

  // Last value of the seconds counter before it rolls over.
  localparam logic [5:0] SEC_LAST = 6'd59;

  // Clock cycles per tick period for a given speed-up factor.
  function automatic int div_of(input int clk_hz, input int tick_hz, input int spd);
    return clk_hz / tick_hz / spd;
  endfunction

  // A divisor is usable only if it is exact, even and at least 2, so that
  // the square wave has two equal, non-empty halves.
  function automatic bit div_ok(input int clk_hz, input int tick_hz, input int spd);
    int d;
    if (tick_hz <= 0 || spd <= 0) return 1'b0;
    d = div_of(clk_hz, tick_hz, spd);
    return (d * tick_hz * spd == clk_hz) && (d >= 2) && (d % 2 == 0);
  endfunction

endpackage

// File: rtl/clock_mod_cnt.sv
// Modulo-N counter: counts 0..limit_i while enabled, then returns to 0.
// wrap_o is combinational and high in the cycle whose clock edge performs
// the wrap, so a consumer can register it as a pulse aligned with the
// counter returning to zero. clr_i has priority over en_i.
module clock_mod_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and fold back at the limit.
  // The >= keeps the counter bounded even if the limit drops below it.
  always_comb begin
    wrap_o = en_i && !clr_i && (cnt_q >= limit_i);
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + W'(1);
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/clock_tick_gen.sv
// Tick generator: divides the board clock down to a one-cycle tick and a
// 50 % square wave, with four run-time speed modes, pause and phase
// restart. The mode in effect is only swapped at a period boundary or a
// sync clear, so no period is ever truncated.
// Optional: define CLOCK_TICK_SEC_CNT_EN to add a mod-60 seconds counter
// (sec_cnt_out) and a minute pulse (min_tick_out).
//
// Handshake: none. en_in is a level enable (low freezes the phase),
// sync_clr_in is a level synchronous restart that beats en_in.
module clock_tick_gen
  import clock_pkg::*;
#(
  parameter int CLK_HZ  = CLK_HZ_DEF,
  parameter int TICK_HZ = TICK_HZ_DEF,
  parameter int SPD1    = SPD1_DEF,
  parameter int SPD2    = SPD2_DEF,
  parameter int SPD3    = SPD3_DEF
) (
  input  logic       clk_in_50M,
  input  logic       rst_in,
  input  logic       en_in,
  input  logic       sync_clr_in,
  input  logic [1:0] mode_in,
  output logic       tick_out,
  output logic       clk_out_sec,
  output logic [1:0] mode_act_out
`ifdef CLOCK_TICK_SEC_CNT_EN
  ,
  output logic [5:0] sec_cnt_out,
  output logic       min_tick_out
`endif
);

  localparam int DIV0 = div_of(CLK_HZ, TICK_HZ, 1);
  localparam int DIV1 = div_of(CLK_HZ, TICK_HZ, SPD1);
  localparam int DIV2 = div_of(CLK_HZ, TICK_HZ, SPD2);
  localparam int DIV3 = div_of(CLK_HZ, TICK_HZ, SPD3);

  // Mode 0 has the longest period, so its width covers every mode.
  localparam int CW = (DIV0 > 1) ? $clog2(DIV0) : 1;

  localparam logic [CW-1:0] LIM0  = CW'(DIV0 - 1);
  localparam logic [CW-1:0] LIM1  = CW'(DIV1 - 1);
  localparam logic [CW-1:0] LIM2  = CW'(DIV2 - 1);
  localparam logic [CW-1:0] LIM3  = CW'(DIV3 - 1);
  localparam logic [CW-1:0] HALF0 = CW'(DIV0 / 2 - 1);
  localparam logic [CW-1:0] HALF1 = CW'(DIV1 / 2 - 1);
  localparam logic [CW-1:0] HALF2 = CW'(DIV2 / 2 - 1);
  localparam logic [CW-1:0] HALF3 = CW'(DIV3 / 2 - 1);

  if (!div_ok(CLK_HZ, TICK_HZ, 1) || !div_ok(CLK_HZ, TICK_HZ, SPD1) ||
      !div_ok(CLK_HZ, TICK_HZ, SPD2) || !div_ok(CLK_HZ, TICK_HZ, SPD3)) begin : g_bad_div
    $error("clock_tick_gen: every divisor must be an exact even integer >= 2");
  end

  mode_e         mode_act_q, mode_act_d;
  logic          tick_q, tick_d;
  logic          sqw_q, sqw_d;
  logic [CW-1:0] limit, half;
  logic [CW-1:0] cnt;
  logic          main_wrap;

  // Period limit and half-period point of the mode currently in effect.
  always_comb begin
    limit = LIM0;
    half  = HALF0;
    case (mode_act_q)
      MODE_X1: begin limit = LIM0; half = HALF0; end
      MODE_S1: begin limit = LIM1; half = HALF1; end
      MODE_S2: begin limit = LIM2; half = HALF2; end
      MODE_S3: begin limit = LIM3; half = HALF3; end
      default: begin limit = LIM0; half = HALF0; end
    endcase
  end

  clock_mod_cnt #(.W(CW)) u_div_cnt (
    .clk_i   (clk_in_50M),
    .rst_i   (rst_in),
    .en_i    (en_in),
    .clr_i   (sync_clr_in),
    .limit_i (limit),
    .cnt_o   (cnt),
    .wrap_o  (main_wrap)
  );

  // Output next-state: tick on wrap, square wave rises at the half point
  // and falls on wrap, new mode latched only at wrap or clear.
  always_comb begin
    tick_d     = 1'b0;
    sqw_d      = sqw_q;
    mode_act_d = mode_act_q;
    if (sync_clr_in) begin
      sqw_d      = 1'b0;
      mode_act_d = mode_e'(mode_in);
    end else if (en_in) begin
      if (main_wrap) begin
        tick_d     = 1'b1;
        sqw_d      = 1'b0;
        mode_act_d = mode_e'(mode_in);
      end else if (cnt == half) begin
        sqw_d = 1'b1;
      end
    end
  end

  // Output registers with asynchronous reset.
  always_ff @(posedge clk_in_50M or posedge rst_in) begin
    if (rst_in) begin
      tick_q     <= 1'b0;
      sqw_q      <= 1'b0;
      mode_act_q <= MODE_X1;
    end else begin
      tick_q     <= tick_d;
      sqw_q      <= sqw_d;
      mode_act_q <= mode_act_d;
    end
  end

  assign tick_out     = tick_q;
  assign clk_out_sec  = sqw_q;
  assign mode_act_out = mode_act_q;

`ifdef CLOCK_TICK_SEC_CNT_EN
  logic [5:0] sec_cnt;
  logic       sec_wrap;
  logic       min_tick_q, min_tick_d;

  // Seconds advance once per tick-producing wrap of the main divider.
  clock_mod_cnt #(.W(6)) u_sec_cnt (
    .clk_i   (clk_in_50M),
    .rst_i   (rst_in),
    .en_i    (main_wrap),
    .clr_i   (sync_clr_in),
    .limit_i (SEC_LAST),
    .cnt_o   (sec_cnt),
    .wrap_o  (sec_wrap)
  );

  // Minute pulse lands on the same edge that returns seconds to 0.
  always_comb begin
    min_tick_d = sec_wrap && !sync_clr_in;
  end

  // Minute pulse register with asynchronous reset.
  always_ff @(posedge clk_in_50M or posedge rst_in) begin
    if (rst_in) min_tick_q <= 1'b0;
    else        min_tick_q <= min_tick_d;
  end

  assign sec_cnt_out  = sec_cnt;
  assign min_tick_out = min_tick_q;
`endif

endmodule

// File: tb/tb_clock_tick_gen.sv
// Bench for clock_tick_gen with a small divisor set (200/20/4/2 cycles).
// A period-level reference model predicts every output each cycle; the
// directed steps then measure tick spacing, square-wave duty and the
// pause/clear/reset corner cases directly.
module tb_clock_tick_gen;

  localparam int CLK_HZ  = 200;
  localparam int TICK_HZ = 1;
  localparam int SPD1    = 10;
  localparam int SPD2    = 50;
  localparam int SPD3    = 100;

  logic       clk = 1'b0;
  logic       rst_in;
  logic       en_in;
  logic       sync_clr_in;
  logic [1:0] mode_in;
  logic       tick_out;
  logic       clk_out_sec;
  logic [1:0] mode_act_out;
  logic [5:0] sec_obs;
  logic       min_obs;

  int n_checks   = 0;
  int n_failures = 0;
  int cyc        = 0;

  // Reference model state: elapsed enabled cycles in the current period,
  // the period length, and the predicted outputs.
  int         m_ph;
  int         m_per;
  logic       m_tick;
  logic       m_sq;
  logic [1:0] m_mode;
  int         m_sec;
  logic       m_min;

  logic [10:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  clock_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .SPD1   (SPD1),
    .SPD2   (SPD2),
    .SPD3   (SPD3)
  ) dut (
    .clk_in_50M  (clk),
    .rst_in      (rst_in),
    .en_in       (en_in),
    .sync_clr_in (sync_clr_in),
    .mode_in     (mode_in),
    .tick_out    (tick_out),
    .clk_out_sec (clk_out_sec),
    .mode_act_out(mode_act_out)
`ifdef CLOCK_TICK_SEC_CNT_EN
    ,
    .sec_cnt_out (sec_obs),
    .min_tick_out(min_obs)
`endif
  );

`ifndef CLOCK_TICK_SEC_CNT_EN
  assign sec_obs = 6'd0;
  assign min_obs = 1'b0;
`endif

  // ---------------- reference model ----------------
  function automatic int period_of(input logic [1:0] m);
    case (m)
      2'd0:    return CLK_HZ / TICK_HZ;
      2'd1:    return CLK_HZ / (TICK_HZ * SPD1);
      2'd2:    return CLK_HZ / (TICK_HZ * SPD2);
      default: return CLK_HZ / (TICK_HZ * SPD3);
    endcase
  endfunction

  task automatic model_reset();
    m_ph   = 0;
    m_mode = 2'd0;
    m_per  = period_of(2'd0);
    m_tick = 1'b0;
    m_sq   = 1'b0;
    m_sec  = 0;
    m_min  = 1'b0;
  endtask

  task automatic model_edge(input logic en, input logic clr, input logic [1:0] mode);
    m_tick = 1'b0;
    m_min  = 1'b0;
    if (clr) begin
      m_ph   = 0;
      m_mode = mode;
      m_per  = period_of(mode);
      m_sq   = 1'b0;
      m_sec  = 0;
    end else if (en) begin
      m_ph = m_ph + 1;
      if (m_ph == m_per) begin
        m_ph   = 0;
        m_tick = 1'b1;
        m_mode = mode;
        m_per  = period_of(mode);
        m_sec  = (m_sec + 1) % 60;
        m_min  = (m_sec == 0);
      end
      // Low for the first half of the period, high for the second half.
      m_sq = (m_ph >= m_per / 2);
    end
`ifndef CLOCK_TICK_SEC_CNT_EN
    m_sec = 0;
    m_min = 1'b0;
`endif
  endtask

  function automatic logic [10:0] model_vec();
    return {m_min, 6'(m_sec), m_mode, m_sq, m_tick};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {min_obs, sec_obs, mode_act_out, clk_out_sec, tick_out};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_failures++;
      $display("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
      $error("check %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic score_cycle(input string tag);
    logic [10:0] e;
    exp_q.push_back(model_vec());
    e = exp_q.pop_front();
    check(tag, int'(dut_vec()), int'(e));
  endtask

  // ---------------- drivers ----------------
  task automatic step(input logic en, input logic clr, input logic [1:0] mode);
    en_in       = en;
    sync_clr_in = clr;
    mode_in     = mode;
    @(posedge clk);
    #1;
    cyc++;
    model_edge(en, clr, mode);
    score_cycle("cycle");
  endtask

  // Run enabled until tick_out is seen; n = cycles taken (-1 if none
  // within max), hi = cycles clk_out_sec was high along the way.
  task automatic wait_tick(input logic [1:0] mode, input int max, output int n, output int hi);
    n  = 0;
    hi = 0;
    do begin
      step(1'b1, 1'b0, mode);
      n++;
      if (clk_out_sec) hi++;
    end while (!tick_out && n < max);
    if (!tick_out) n = -1;
  endtask

  task automatic async_reset_mid_cycle();
    #3;
    rst_in = 1'b1;
    #1;
    model_reset();
    score_cycle("async_rst");
    @(posedge clk);
    #1;
    cyc++;
    score_cycle("rst_hold");
    rst_in = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : main
    int n;
    int hi;
    int tot;
    int mins;
    logic [1:0] rmode;

    rst_in      = 1'b1;
    en_in       = 1'b0;
    sync_clr_in = 1'b0;
    mode_in     = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_tick", int'(tick_out), 0);
    check("rst_sq", int'(clk_out_sec), 0);
    check("rst_mode", int'(mode_act_out), 0);
    check("rst_sec", int'(sec_obs), 0);
    rst_in = 1'b0;

    // 1: mode 0 from a sync clear: first tick after 200, then every 200,
    //    square wave 100 high per period.
    step(1'b1, 1'b1, 2'd0);
    wait_tick(2'd0, 250, n, hi);
    check("t1_first_tick", n, 200);
    check("t1_first_hi", hi, 100);
    wait_tick(2'd0, 250, n, hi);
    check("t1_period", n, 200);
    check("t1_hi", hi, 100);

    // 2: mode request at cycle 50 waits for the wrap.
    repeat (50) step(1'b1, 1'b0, 2'd0);
    check("t2_mode_before", int'(mode_act_out), 0);
    wait_tick(2'd1, 250, n, hi);
    check("t2_rest_of_period", n, 150);
    check("t2_mode_after", int'(mode_act_out), 1);
    wait_tick(2'd1, 250, n, hi);
    check("t2_fast_period", n, 20);
    check("t2_fast_hi", hi, 10);

    // 3: DIV = 2, tick every other cycle, square wave toggles each cycle.
    step(1'b1, 1'b1, 2'd3);
    for (int i = 0; i < 3; i++) begin
      wait_tick(2'd3, 10, n, hi);
      check("t3_period", n, 2);
      check("t3_hi", hi, 1);
    end

    // 4: mode 2, pause 7 cycles at cnt = 1; tick slips by exactly 7.
    step(1'b1, 1'b1, 2'd2);
    step(1'b1, 1'b0, 2'd2);
    tot = 1;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 2'd2);
      check("t4_no_tick", int'(tick_out), 0);
      tot++;
    end
    wait_tick(2'd2, 40, n, hi);
    check("t4_delayed_tick", tot + n, 4 + 7);

    // 5: clear at cnt = DIV-1 beats the wrap; then async reset mid-period.
    step(1'b1, 1'b1, 2'd2);
    repeat (3) step(1'b1, 1'b0, 2'd2);
    step(1'b1, 1'b1, 2'd2);
    check("t5_clr_no_tick", int'(tick_out), 0);
    check("t5_clr_sq", int'(clk_out_sec), 0);
    wait_tick(2'd2, 40, n, hi);
    check("t5_restart_period", n, 4);
    repeat (2) step(1'b1, 1'b0, 2'd2);
    async_reset_mid_cycle();
    check("t5_rst_mode", int'(mode_act_out), 0);
    check("t5_rst_sq", int'(clk_out_sec), 0);

`ifdef CLOCK_TICK_SEC_CNT_EN
    // 6: seconds counter in mode 3: 59 after 118 cycles, minute on the 60th tick.
    step(1'b1, 1'b1, 2'd3);
    mins = 0;
    for (int i = 0; i < 118; i++) begin
      step(1'b1, 1'b0, 2'd3);
      if (min_obs) mins++;
    end
    check("t6_sec59", int'(sec_obs), 59);
    check("t6_no_min_yet", mins, 0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 2'd3);
      if (min_obs) mins++;
    end
    check("t6_min_pulse", int'(min_obs), 1);
    check("t6_sec_wrap", int'(sec_obs), 0);
    step(1'b1, 1'b0, 2'd3);
    check("t6_min_once", mins + int'(min_obs), 1);
    repeat (5) step(1'b1, 1'b0, 2'd3);
    step(1'b1, 1'b1, 2'd3);
    check("t6_clr_sec", int'(sec_obs), 0);
`endif

    // Random phase: mostly enabled, occasional pauses, clears and mode changes.
    rmode = 2'($urandom_range(0, 3));
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) rmode = 2'($urandom_range(0, 3));
      step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 99) == 0), rmode);
      if ($urandom_range(0, 999) == 0) begin
        async_reset_mid_cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    n_failures++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $fatal(1, "bench timed out");
  end

endmodule
